// File: rtl/prog_counter_pkg.sv
// rtl/prog_counter_pkg.sv - shared PC source select encoding and default sizes
package prog_counter_pkg;

   localparam int PC_ADDR_W    = 10;
   localparam int PC_RAS_DEPTH = 8;

   typedef enum logic [1:0] {
      SEL_IMMED = 2'd0,
      SEL_STACK = 2'd1,
      SEL_INTR  = 2'd2,
      SEL_RAS   = 2'd3
   } pc_sel_t;

endpackage

// File: rtl/ras_lifo.sv
// rtl/ras_lifo.sv - circular return-address LIFO with full/empty and sticky error flags
module ras_lifo
   import prog_counter_pkg::*;
#(
   parameter int ADDR_W    = PC_ADDR_W,
   parameter int RAS_DEPTH = PC_RAS_DEPTH
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic              peek_i,
   input  logic [ADDR_W-1:0] push_data_i,
   output logic [ADDR_W-1:0] top_o,
   output logic              empty_o,
   output logic              full_o,
   output logic              ovf_o,
   output logic              unf_o
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
   logic [PTR_W-1:0]  ptr_q, ptr_d, wr_ptr;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d, unf_q, unf_d, wr_en;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CNT_W'(RAS_DEPTH));
   assign top_o   = empty_o ? '0 : mem_q[ptr_q];
   assign ovf_o   = ovf_q;
   assign unf_o   = unf_q;

   always_comb begin
      ptr_d  = ptr_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      unf_d  = unf_q;
      wr_en  = 1'b0;
      wr_ptr = ptr_q;
      if (push_i && pop_i && !empty_o) begin
         wr_en = 1'b1;
      end else if (push_i) begin
         // when full, the slot after the top holds the oldest entry, so it is overwritten
         wr_en  = 1'b1;
         wr_ptr = ptr_q + PTR_W'(1);
         ptr_d  = wr_ptr;
         if (full_o) ovf_d = 1'b1;
         else        cnt_d = cnt_q + CNT_W'(1);
      end else if (pop_i) begin
         if (empty_o) begin
            unf_d = 1'b1;
         end else begin
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
      if (peek_i && empty_o) unf_d = 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST && wr_en) mem_q[wr_ptr] <= push_data_i;
   end

endmodule

// File: rtl/prog_counter_ras.sv
// rtl/prog_counter_ras.sv - program counter with source mux and integrated return-address stack
module prog_counter_ras
   import prog_counter_pkg::*;
#(
   parameter int              ADDR_W    = PC_ADDR_W,
   parameter int              RAS_DEPTH = PC_RAS_DEPTH,
   parameter logic [ADDR_W-1:0] INTR_VEC = '1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              PC_LD,
   input  logic              PC_INC,
   input  logic [1:0]        PC_MUX_SEL,
   input  logic [ADDR_W-1:0] FROM_IMMED,
   input  logic [ADDR_W-1:0] FROM_STACK,
   input  logic              RAS_PUSH,
   input  logic              RAS_POP,
   output logic [ADDR_W-1:0] PC_COUNT,
   output logic [ADDR_W-1:0] RAS_TOP,
   output logic              RAS_EMPTY,
   output logic              RAS_FULL,
   output logic              RAS_OVF,
   output logic              RAS_UNF
);

   logic [ADDR_W-1:0] pc_q, pc_d, pc_plus1, src_sel;
   logic              ras_peek;

   assign pc_plus1 = pc_q + ADDR_W'(1);
   assign PC_COUNT = pc_q;
   assign ras_peek = PC_LD && (pc_sel_t'(PC_MUX_SEL) == SEL_RAS);

   always_comb begin
      src_sel = FROM_IMMED;
      case (pc_sel_t'(PC_MUX_SEL))
         SEL_IMMED: src_sel = FROM_IMMED;
         SEL_STACK: src_sel = FROM_STACK;
         SEL_INTR:  src_sel = INTR_VEC;
         SEL_RAS:   src_sel = RAS_TOP;
         default:   src_sel = FROM_IMMED;
      endcase
   end

   always_comb begin
      pc_d = pc_q;
      if (PC_LD)       pc_d = src_sel;
      else if (PC_INC) pc_d = pc_plus1;
   end

   always_ff @(posedge CLK) begin
      if (RST) pc_q <= '0;
      else     pc_q <= pc_d;
   end

   // the return address is always the instruction after the current one
   ras_lifo #(
      .ADDR_W    (ADDR_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .CLK         (CLK),
      .RST         (RST),
      .push_i      (RAS_PUSH),
      .pop_i       (RAS_POP),
      .peek_i      (ras_peek),
      .push_data_i (pc_plus1),
      .top_o       (RAS_TOP),
      .empty_o     (RAS_EMPTY),
      .full_o      (RAS_FULL),
      .ovf_o       (RAS_OVF),
      .unf_o       (RAS_UNF)
   );

endmodule
